dff_checker: RTL and testbench

- Receiving-end monitor for a D flip-flop under test. Consumes the flop's D/C stimulus and its Q/nQ outputs.
- Captures the expected value on each rising clock edge, then compares it against Q after a configurable settle depth.
- Checks Q/nQ complementarity, and keeps saturating edge, toggle and error counters plus a sticky fault record.
- Instantiated in flop testbenches alongside the flop, sharing its clock, so a regression can pass or fail without VCD inspection.

---
 rtl/dff_checker.sv | 102 ++++++++++
 tb/tb_dff_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_checker.sv
// Receiving-end monitor for a D flip-flop under test: compares sampled Q against D
// captured SETTLE edges earlier, checks Q/nQ complementarity and keeps saturating counters.
`timescale 1ns/1ps
module dff_checker #(
  parameter int CNT_W       = 8,
  parameter int SETTLE      = 1,
  parameter int STOP_ON_SAT = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             D,
  input  logic             Q,
  input  logic             nQ,
  output logic             err,
  output logic [1:0]       err_kind,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic [CNT_W-1:0] first_err_edge,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            cur_state, nxt_state;
  logic [SETTLE-1:0] pipe_val, pipe_vld;
  logic              q_prev, prev_ok;
  logic              mismatch, comp_fault, fault, tog_hit;
  logic [CNT_W-1:0]  edge_nxt, err_nxt;

  assign state = cur_state;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    mismatch   = 1'b0;
    comp_fault = 1'b0;
    if (cur_state == FILL || cur_state == RUN) begin
      // !== so an X or Z on Q is reported rather than silently passing.
      mismatch = pipe_vld[SETTLE-1] && (Q !== pipe_val[SETTLE-1]);
    end
    if (cur_state == RUN) begin
      comp_fault = (Q === nQ);
    end
    fault    = mismatch || comp_fault;
    tog_hit  = prev_ok && (Q != q_prev);
    edge_nxt = (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + 1'b1;
    err_nxt  = (fault && err_cnt != CNT_MAX) ? err_cnt + 1'b1 : err_cnt;

    nxt_state = cur_state;
    case (cur_state)
      IDLE: nxt_state = FILL;
      FILL: if (pipe_vld[SETTLE-1]) nxt_state = RUN;
      RUN:  if (STOP_ON_SAT != 0 && err_nxt == CNT_MAX) nxt_state = HALT;
      default: nxt_state = HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      cur_state      <= IDLE;
      // NOTE: the expectation pipe is reset, not left to power-up values,
      // because its valid bits gate the mismatch check.
      pipe_val       <= '0;
      pipe_vld       <= '0;
      q_prev         <= 1'b0;
      prev_ok        <= 1'b0;
      err            <= 1'b0;
      err_kind       <= 2'b00;
      err_cnt        <= '0;
      edge_cnt       <= '0;
      tog_cnt        <= '0;
      first_err_edge <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state != HALT) begin
        pipe_val[0] <= D;
        pipe_vld[0] <= 1'b1;
        for (int i = 1; i < SETTLE; i++) begin
          pipe_val[i] <= pipe_val[i-1];
          pipe_vld[i] <= pipe_vld[i-1];
        end
        edge_cnt <= edge_nxt;
        q_prev   <= Q;
        prev_ok  <= 1'b1;
        if (tog_hit && tog_cnt != CNT_MAX) tog_cnt <= tog_cnt + 1'b1;
        if (fault) begin
          err      <= 1'b1;
          err_cnt  <= err_nxt;
          err_kind <= err_kind | {comp_fault, mismatch};
          // err still clear means this is the first faulting edge.
          if (!err) first_err_edge <= edge_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_checker.sv
// Scoreboard bench for dff_checker: three instances (default, 4-bit saturating, SETTLE=3)
// share clock, reset and D; expected snapshots are queued per edge and popped after it.
`timescale 1ns/1ps
module tb_dff_checker;

  typedef struct packed {
    logic [1:0] st;
    logic       err;
    logic [1:0] kind;
    logic [7:0] ec;
    logic [7:0] edg;
    logic [7:0] tog;
    logic [7:0] first;
  } snap_t;

  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2, S_HALT = 2'd3;

  logic clk = 1'b0, rst = 1'b1, d = 1'b0;
  logic q_sel = 1'b0, q_frc = 1'b0, nq_frc = 1'b1;
  logic fq, lag1, lag2;
  logic q, nq, q3, nq3;

  int    total = 0, bad = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  // Behavioural flop under test plus a two-edge lag chain for the SETTLE=3 instance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq <= 1'b0; lag1 <= 1'b0; lag2 <= 1'b0;
    end else begin
      fq <= d; lag1 <= fq; lag2 <= lag1;
    end
  end

  assign q   = q_sel ? q_frc  : fq;
  assign nq  = q_sel ? nq_frc : ~fq;
  assign q3  = lag2;
  assign nq3 = ~lag2;

  logic       a_err, b_err, c_err;
  logic [1:0] a_kind, b_kind, c_kind, a_st, b_st, c_st;
  logic [7:0] a_ec, a_edg, a_tog, a_first, c_ec, c_edg, c_tog, c_first;
  logic [3:0] b_ec, b_edg, b_tog, b_first;
  snap_t      obs_a, obs_b, obs_c;

  dff_checker #(.CNT_W(8), .SETTLE(1), .STOP_ON_SAT(1)) dut_a (
    .C(clk), .R(rst), .D(d), .Q(q), .nQ(nq),
    .err(a_err), .err_kind(a_kind), .err_cnt(a_ec), .edge_cnt(a_edg),
    .tog_cnt(a_tog), .first_err_edge(a_first), .state(a_st));

  dff_checker #(.CNT_W(4), .SETTLE(1), .STOP_ON_SAT(1)) dut_b (
    .C(clk), .R(rst), .D(d), .Q(q), .nQ(nq),
    .err(b_err), .err_kind(b_kind), .err_cnt(b_ec), .edge_cnt(b_edg),
    .tog_cnt(b_tog), .first_err_edge(b_first), .state(b_st));

  dff_checker #(.CNT_W(8), .SETTLE(3), .STOP_ON_SAT(1)) dut_c (
    .C(clk), .R(rst), .D(d), .Q(q3), .nQ(nq3),
    .err(c_err), .err_kind(c_kind), .err_cnt(c_ec), .edge_cnt(c_edg),
    .tog_cnt(c_tog), .first_err_edge(c_first), .state(c_st));

  assign obs_a = {a_st, a_err, a_kind, a_ec, a_edg, a_tog, a_first};
  assign obs_b = {b_st, b_err, b_kind, 4'h0, b_ec, 4'h0, b_edg, 4'h0, b_tog, 4'h0, b_first};
  assign obs_c = {c_st, c_err, c_kind, c_ec, c_edg, c_tog, c_first};

  function automatic snap_t mk(input logic [1:0] st, input logic e, input logic [1:0] kd,
                               input int ec, input int edg, input int tog, input int first);
    snap_t s;
    s.st    = st;
    s.err   = e;
    s.kind  = kd;
    s.ec    = ec[7:0];
    s.edg   = edg[7:0];
    s.tog   = tog[7:0];
    s.first = first[7:0];
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    snap_t want;
    #2;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(S_IDLE, 1'b0, 2'b00, 0, 0, 0, 0));
      if (i == 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL reset_a step=%0d got=%h want=%h", i, obs_a, want);
      end
      total++;
      if (obs_c !== want) begin
        bad++;
        $display("FAIL reset_c step=%0d got=%h want=%h", i, obs_c, want);
      end
    end
  endtask

  task automatic test_correct_flop();
    snap_t want;
    logic  qv, qprev;
    int    tog;
    q_sel = 1'b0; d = 1'b0;
    do_reset();
    fork
      begin
        #0.5;
        repeat (15) begin
          #13 d = ~d;
        end
      end
    join_none
    tog = 0; qprev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      qv = q;
      if (k > 1 && qv != qprev) tog++;
      qprev = qv;
      exp_q.push_back(mk(k == 1 ? S_FILL : S_RUN, 1'b0, 2'b00, 0, k, tog, 0));
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL correct_flop edge=%0d got=%h want=%h", k, obs_a, want);
      end
    end
  endtask

  task automatic test_mismatch();
    snap_t want;
    q_sel = 1'b1; q_frc = 1'b0; nq_frc = 1'b1; d = 1'b1;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) exp_q.push_back(mk(S_FILL, 1'b0, 2'b00, 0, 1, 0, 0));
      else        exp_q.push_back(mk(S_RUN, 1'b1, 2'b01, k - 1, k, 0, 2));
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL q_mismatch edge=%0d got=%h want=%h", k, obs_a, want);
      end
    end
  endtask

  task automatic test_both_faults();
    snap_t want;
    q_sel = 1'b0; d = 1'b0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        q_sel = 1'b1; q_frc = 1'b1; nq_frc = 1'b1;
      end
      if (k == 1)      exp_q.push_back(mk(S_FILL, 1'b0, 2'b00, 0, 1, 0, 0));
      else if (k == 2) exp_q.push_back(mk(S_RUN, 1'b0, 2'b00, 0, 2, 0, 0));
      else             exp_q.push_back(mk(S_RUN, 1'b1, 2'b11, k - 2, k, 1, 3));
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL both_faults edge=%0d got=%h want=%h", k, obs_a, want);
      end
    end
  endtask

  task automatic test_saturation();
    snap_t    want;
    logic [1:0] st;
    q_sel = 1'b1; q_frc = 1'b0; nq_frc = 1'b1; d = 1'b1;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      // Once halted, wiggle Q to show the toggle counter stays frozen too.
      if (k >= 17) begin
        q_frc = ~q_frc; nq_frc = ~q_frc;
      end
      st = (k == 1) ? S_FILL : (k < 16) ? S_RUN : S_HALT;
      if (k == 1) exp_q.push_back(mk(st, 1'b0, 2'b00, 0, 1, 0, 0));
      else        exp_q.push_back(mk(st, 1'b1, 2'b01, (k - 1 > 15) ? 15 : k - 1,
                                     (k > 15) ? 15 : k, 0, 2));
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      if (obs_b !== want) begin
        bad++;
        $display("FAIL saturation edge=%0d got=%h want=%h", k, obs_b, want);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t want;
    q_sel = 1'b1; q_frc = 1'b0; nq_frc = 1'b1; d = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back(mk(S_RUN, 1'b1, 2'b01, 3, 4, 0, 2));
    want = exp_q.pop_front();
    total++;
    if (obs_a !== want) begin
      bad++;
      $display("FAIL pre_reset got=%h want=%h", obs_a, want);
    end
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(mk(S_IDLE, 1'b0, 2'b00, 0, 0, 0, 0));
    want = exp_q.pop_front();
    total++;
    if (obs_a !== want) begin
      bad++;
      $display("FAIL async_reset_a got=%h want=%h", obs_a, want);
    end
    total++;
    if (obs_b !== want) begin
      bad++;
      $display("FAIL async_reset_b got=%h want=%h", obs_b, want);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_settle3();
    snap_t       want;
    logic [15:0] pat;
    logic        qv, qprev;
    int          tog;
    pat = 16'b1011_0010_1110_0101;
    d = 1'b0;
    do_reset();
    tog = 0; qprev = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      d  = pat[k-1];
      qv = q3;
      if (k > 1 && qv != qprev) tog++;
      qprev = qv;
      exp_q.push_back(mk(k <= 3 ? S_FILL : S_RUN, 1'b0, 2'b00, 0, k, tog, 0));
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      if (obs_c !== want) begin
        bad++;
        $display("FAIL settle3 edge=%0d got=%h want=%h", k, obs_c, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_flop();
    test_mismatch();
    test_both_faults();
    test_saturation();
    test_async_reset();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
